nibble_descrambler: RTL and testbench



---
 rtl/nibble_link_pkg.sv | 24 ++
 rtl/nibble_keystream.sv | 70 +++++++
 rtl/nibble_descrambler.sv | 77 +++++++
 tb/tb_nibble_descrambler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_link_pkg.sv
// nibble_link_pkg
// Shared definitions for the 4-bit nibble link scrambler/descrambler pair.
// Both ends of the link must use the same LFSR width, tap mask, seed and step
// function, or the keystreams drift apart.
//   LFSR_W    : LFSR state width
//   POLY      : tap mask, x^7 + x^6 + 1 (taps s[6], s[5])
//   SEED      : reset value and substitute for a rejected all-zero seed
//   lfsr_step : one LFSR step, returns {keystream bit, next state}
package nibble_link_pkg;

  localparam int                LFSR_W = 7;
  localparam logic [LFSR_W-1:0] POLY   = 7'h60;
  localparam logic [LFSR_W-1:0] SEED   = 7'h7F;

  typedef logic [3:0]        nibble_t;
  typedef logic [LFSR_W-1:0] lfsr_t;

  // The keystream bit is the MSB before shifting; the feedback bit is the
  // parity of the tapped state bits and enters at the LSB.
  function automatic logic [LFSR_W:0] lfsr_step(input lfsr_t s);
    return {s[LFSR_W-1], s[LFSR_W-2:0], ^(s & POLY)};
  endfunction

endpackage

// File: rtl/nibble_keystream.sv
// nibble_keystream
// Holds the descrambler LFSR and produces one 4-bit key nibble per beat.
// The four LFSR steps of a beat are unrolled combinationally, so the key for
// the current state is always available and the state jumps four steps on
// each advance.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (LFSR returns to SEED)
//   load     in   load seed into the LFSR this cycle (wins over advance)
//   seed     in   seed value used when load=1
//   advance  in   step the LFSR four times (one accepted beat)
//   key      out  key nibble for the current state, first bit in bit 3
//   seed_err out  one-cycle pulse after an all-zero seed was rejected
module nibble_keystream
  import nibble_link_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  lfsr_t   seed,
  input  logic    advance,
  output nibble_t key,
  output logic    seed_err
);

  lfsr_t             lfsr_q, lfsr_d;
  logic              seed_err_q, seed_err_d;
  lfsr_t             stage    [0:4];
  logic [LFSR_W:0]   step_res [0:3];

  assign stage[0] = lfsr_q;

  // Unrolled four-step chain; step gi supplies key bit 3-gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
      assign step_res[gi]  = lfsr_step(stage[gi]);
      assign stage[gi+1]   = step_res[gi][LFSR_W-1:0];
      assign key[3-gi]     = step_res[gi][LFSR_W];
    end
  endgenerate

  always_comb begin
    lfsr_d     = lfsr_q;
    seed_err_d = 1'b0;
    if (load) begin
      // An all-zero state would lock the LFSR, so substitute the default seed.
      if (seed == '0) begin
        lfsr_d     = SEED;
        seed_err_d = 1'b1;
      end else begin
        lfsr_d = seed;
      end
    end else if (advance) begin
      lfsr_d = stage[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= SEED;
      seed_err_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign seed_err = seed_err_q;

endmodule

// File: rtl/nibble_descrambler.sv
// nibble_descrambler
// Receive end of the nibble link: XORs each accepted scrambled nibble with
// the LFSR key nibble and presents the plain nibble in a registered output
// stage with a valid/ready handshake (one cycle of latency, full throughput).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load seed into the LFSR this cycle (blocks acceptance)
//   seed       in   seed value used when seed_load=1
//   in_valid   in   scrambled nibble present
//   in_ready   out  nibble accepted this cycle when in_valid=1
//   in_data    in   scrambled nibble
//   out_valid  out  plain nibble held in output register
//   out_ready  in   downstream takes the nibble
//   out_data   out  plain nibble
//   seed_err   out  one-cycle pulse: zero seed rejected
module nibble_descrambler
  import nibble_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic              seed_err
);

  logic    out_valid_q, out_valid_d;
  nibble_t out_data_q,  out_data_d;
  nibble_t key;
  logic    accept;

  // A reseed cycle never accepts, so the beat arriving alongside it is
  // simply held by the sender and descrambled with the new key.
  assign in_ready = !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  nibble_keystream u_keystream (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .seed     (seed),
    .advance  (accept),
    .key      (key),
    .seed_err (seed_err)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_data_d  = in_data ^ key;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 4'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_nibble_descrambler.sv
module tb_nibble_descrambler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_load;
  logic [6:0] seed;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       seed_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_descrambler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .seed_err  (seed_err)
  );

  // Reference scrambler: x^7+x^6+1, key bit = MSB, first bit into key[3].
  function automatic logic [6:0] ref_adv(input logic [6:0] s);
    logic [6:0] t;
    t = s;
    for (int i = 0; i < 4; i++) t = {t[5:0], t[6] ^ t[5]};
    return t;
  endfunction

  function automatic logic [3:0] ref_key(input logic [6:0] s);
    logic [6:0] t;
    logic [3:0] k;
    t = s;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[3-i] = t[6];
      t = {t[5:0], t[6] ^ t[5]};
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [6:0] sc;
  logic [3:0] plain, scr, rx_d;
  logic       tx, rx;
  logic [3:0] exp_q[$];
  int         sent, recv;

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_out_data", {4'b0, out_data}, 8'h00);
    check("rst_seed_err", {7'b0, seed_err}, 8'h00);
    check("rst_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h7F);
    rst_n = 1'b1;

    // Back-to-back F then A with out_ready high
    in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {7'b0, in_ready}, 8'h01);
    tick();
    check("b2b1_valid", {7'b0, out_valid}, 8'h01);
    check("b2b1_data", {4'b0, out_data}, 8'h00);
    check("b2b1_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h70);
    in_data = 4'hA;
    tick();
    check("b2b2_valid", {7'b0, out_valid}, 8'h01);
    check("b2b2_data", {4'b0, out_data}, 8'h04);
    check("b2b2_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h02);
    in_valid = 1'b0;
    tick();
    check("drain_valid", {7'b0, out_valid}, 8'h00);
    check("drain_data_hold", {4'b0, out_data}, 8'h04);

    // Stall: out_ready low after first beat
    do_reset();
    in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0;
    tick();
    check("stall1_data", {4'b0, out_data}, 8'h00);
    in_data = 4'hA;
    #1;
    check("stall_in_ready", {7'b0, in_ready}, 8'h00);
    tick(); tick();
    check("stall_valid", {7'b0, out_valid}, 8'h01);
    check("stall_data", {4'b0, out_data}, 8'h00);
    check("stall_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h70);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {7'b0, in_ready}, 8'h01);
    tick();
    check("release_data", {4'b0, out_data}, 8'h04);
    check("release_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h02);
    in_valid = 1'b0;
    tick();

    // Reseed with 7F while a beat is offered
    seed_load = 1'b1; seed = 7'h7F; in_valid = 1'b1; in_data = 4'hF;
    #1;
    check("seed_in_ready", {7'b0, in_ready}, 8'h00);
    tick();
    check("seed_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h7F);
    check("seed_no_err", {7'b0, seed_err}, 8'h00);
    check("seed_no_accept", {7'b0, out_valid}, 8'h00);
    seed_load = 1'b0;
    tick();
    check("seed_beat_data", {4'b0, out_data}, 8'h00);
    check("seed_beat_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h70);

    // Zero seed while the output is held pending
    in_valid = 1'b0; out_ready = 1'b0; seed_load = 1'b1; seed = 7'h00;
    tick();
    check("zseed_err", {7'b0, seed_err}, 8'h01);
    check("zseed_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h7F);
    check("zseed_out_valid_kept", {7'b0, out_valid}, 8'h01);
    seed_load = 1'b0;
    tick();
    check("zseed_err_pulse", {7'b0, seed_err}, 8'h00);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    tick();
    check("zseed_beat_data", {4'b0, out_data}, 8'h00);
    check("zseed_beat_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h70);
    in_valid = 1'b0;
    tick();

    // Loopback of 200 random nibbles with random backpressure
    do_reset();
    sc = 7'h7F; sent = 0; recv = 0;
    plain = 4'($urandom_range(0, 15));
    scr = plain ^ ref_key(sc);
    for (int cyc = 0; cyc < 5000 && recv < 200; cyc++) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_data   = scr;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      tx = in_valid && in_ready;
      rx = out_valid && out_ready;
      rx_d = out_data;
      tick();
      if (rx) begin
        if (exp_q.size() == 0) check("loop_extra", 8'h01, 8'h00);
        else check("loop_data", {4'b0, rx_d}, {4'b0, exp_q.pop_front()});
        recv++;
      end
      if (tx) begin
        exp_q.push_back(plain);
        sent++;
        sc = ref_adv(sc);
        plain = 4'($urandom_range(0, 15));
        scr = plain ^ ref_key(sc);
      end
    end
    check("loop_recv_count", 8'(recv), 8'd200);
    check("loop_sent_count", 8'(sent), 8'd200);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Async reset while stalled with a pending nibble
    do_reset();
    in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0;
    tick();
    check("pre_arst_valid", {7'b0, out_valid}, 8'h01);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {7'b0, out_valid}, 8'h00);
    check("arst_lfsr", {1'b0, dut.u_keystream.lfsr_q}, 8'h7F);
    tick();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    tick();
    check("post_arst_data", {4'b0, out_data}, 8'h00);
    check("post_arst_valid", {7'b0, out_valid}, 8'h01);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
